// File: rtl/awd_ise.sv
// Byte-serial 32-bit modular adder with optional byte rotate-left.
// The core issues one command per byte: four loads, one control step, then three unloads.
module awd_ise #(
  parameter int ROT_BYTES = 1,
  parameter int CFLAG_BIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] sr,
  output logic [7:0] sr_out,
  output logic [7:0] result,
  output logic       wait_req
);

  typedef enum logic [2:0] {
    LOAD0 = 3'd0,
    LOAD1 = 3'd1,
    LOAD2 = 3'd2,
    LOAD3 = 3'd3,
    CTRL  = 3'd4,
    UNL2  = 3'd5,
    UNL1  = 3'd6,
    UNL0  = 3'd7
  } phase_t;

  phase_t      phase_reg, phase_next;
  logic        wait_reg;
  logic [7:0]  a_reg, b_reg;
  logic [31:0] sum_reg, sum_next;
  logic        cin_reg, cin_next;
  logic        cflag_reg, cflag_next;
  logic [7:0]  result_reg, result_next;
  logic [31:0] rot_word;
  logic [8:0]  byte_sum;
  logic        cin_in;
  logic [31:0] ctrl_word;
  logic        accept;

  assign accept = start & ~wait_reg;

  // Byte i of the rotated word comes from byte (i - ROT_BYTES) mod 4.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      localparam int SRC = (gi + 4 - (ROT_BYTES % 4)) % 4;
      assign rot_word[8*gi +: 8] = sum_reg[8*SRC +: 8];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sr
      if (gi == CFLAG_BIT) begin : g_flag
        assign sr_out[gi] = cflag_reg;
      end else begin : g_pass
        assign sr_out[gi] = sr[gi];
      end
    end
  endgenerate

  // State register: operands are captured on accept, work happens on the EXEC edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg  <= LOAD0;
      wait_reg   <= 1'b0;
      a_reg      <= 8'h00;
      b_reg      <= 8'h00;
      sum_reg    <= 32'h0;
      cin_reg    <= 1'b0;
      cflag_reg  <= 1'b0;
      result_reg <= 8'h00;
    end else begin
      wait_reg   <= accept;
      if (accept) begin
        a_reg <= a;
        b_reg <= b;
      end
      phase_reg  <= phase_next;
      sum_reg    <= sum_next;
      cin_reg    <= cin_next;
      cflag_reg  <= cflag_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    phase_next = phase_reg;
    if (wait_reg) begin
      phase_next = phase_t'(3'(phase_reg + 3'd1));
    end
  end

  assign cin_in    = (phase_reg == LOAD0) ? 1'b0 : cin_reg;
  assign byte_sum  = {1'b0, a_reg} + {1'b0, b_reg} + {8'h00, cin_in};
  assign ctrl_word = a_reg[0] ? rot_word : sum_reg;

  always_comb begin
    sum_next    = sum_reg;
    cin_next    = cin_reg;
    cflag_next  = cflag_reg;
    result_next = result_reg;
    if (wait_reg) begin
      case (phase_reg)
        LOAD0, LOAD1, LOAD2, LOAD3: begin
          sum_next[{phase_reg[1:0], 3'b000} +: 8] = byte_sum[7:0];
          cin_next = byte_sum[8];
        end
        CTRL: begin
          sum_next    = ctrl_word;
          cflag_next  = cin_reg;
          result_next = ctrl_word[31:24];
        end
        UNL2: result_next = sum_reg[23:16];
        UNL1: result_next = sum_reg[15:8];
        UNL0: begin
          result_next = sum_reg[7:0];
          cin_next    = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result   = result_reg;
  assign wait_req = wait_reg;

endmodule

// File: doc/awd_ise.md
Name: awd_ise

Overview:
- Byte-serial 32-bit modular-add ISE for the CHAM round datapath on the 8-bit HOKSTER core. Computes (X + Y) mod 2^32 with an optional left rotate by ROT_BYTES bytes.
- Sits directly downstream of the 32-bit word-rotate ISE: the core feeds the rotated word into this block as one operand, then reads back the sum.
- Same start/wait_req handshake as the other ISEs. Final carry is reported through the status register.

Parameters:
- ROT_BYTES, 1, byte rotate-left amount applied when ctrl bit 0 is set; legal range 0..3.
- CFLAG_BIT, 0, bit index of the carry flag in sr/sr_out; legal range 0..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle command strobe from the core.
- a  input  8  operand byte of X in LOAD; control byte in CTRL.
- b  input  8  operand byte of Y in LOAD; ignored otherwise.
- sr  input  8  current status register.
- sr_out  output  8  sr with bit CFLAG_BIT replaced by the registered carry flag.
- result  output  8  result byte.
- wait_req  output  1  busy; the core stalls while high.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - result=8'h00, wait_req=0, carry flag=0, internal carry=0, sum register=0, phase=LOAD0.
  - Overrides any operation in progress, including mid-LOAD, mid-UNLOAD, or while wait_req=1.
- Handshake:
  - A command is accepted when start=1 at a rising edge with wait_req=0.
  - On that edge the block captures a and b, and wait_req goes 1 for exactly one cycle (EXEC).
  - At the next edge wait_req returns to 0 and the phase work completes. result is valid from that point.
  - start while wait_req=1 is ignored and not queued.
  - start held high across several idle cycles counts once per accepting edge.
- Phase sequence: LOAD0 -> LOAD1 -> LOAD2 -> LOAD3 -> CTRL -> UNL2 -> UNL1 -> UNL0 -> LOAD0. Each accepted command advances exactly one phase.
- LOADk (k=0 is the LSB):
  - s = a + b + cin (9 bits). Store sum byte k = s[7:0]; cin <= s[8].
  - LOAD0 forces cin=0 regardless of leftover state.
  - result unchanged.
- CTRL:
  - W = sum word. If a[0]=1, W <= rotl(W, 8*ROT_BYTES); otherwise unchanged. a[7:1] ignored.
  - Carry flag <= cin, i.e. the carry out of bit 31 before rotation.
  - result <= W[31:24] (post-rotation).
- UNL2 / UNL1 / UNL0: result <= W[23:16], W[15:8], W[7:0] respectively.
- After UNL0: internal cin cleared. The carry flag holds until the next CTRL or reset.
- sr_out: combinational pass-through of sr, except bit CFLAG_BIT = carry-flag register.
- Arithmetic:
  - Everything is mod 2^32; no saturation.
  - A rotate by ROT_BYTES=0 is the identity.
- Latency: 1 EXEC cycle per command. One full operation takes 8 commands, 16 cycles minimum.

Test Plan:
- X=0x00000001, Y=0x00000001, ctrl=0x00 -> result bytes 00,00,00,02 (CTRL then UNL2..UNL0); sr_out[0]=0 with sr=0x00.
- X=0x000000FF, Y=0x00000001, ctrl=0x00 -> 00,00,01,00, showing the inter-byte carry ripple; sr_out[0]=0.
- X=0xFFFFFFFF, Y=0x00000001, ctrl=0x00 -> 00,00,00,00; sr_out[0]=1; with sr=0xA4, sr_out=0xA5.
- X=0x12345678, Y=0x11111111, ctrl=0x01, ROT_BYTES=1 -> sum 0x23456789, output 45,67,89,23; sr_out[0]=0.
- start pulsed during the EXEC cycle of LOAD1 -> ignored; phase advances by one only; results match the undisturbed run.
- Reset mid-operation:
  - Stimulus: LOAD0 with a=0xFF, b=0x01 (internal carry set), then rst for 1 cycle.
  - Then run the full op X=0, Y=0, ctrl=0x00.
  - Required: 00,00,00,00 and sr_out[0]=0; result and wait_req are 0 in the cycle after rst.
